// File: rtl/jtag_scan_master.sv
// JTAG scan master: turns reset / IR scan / DR scan / idle commands into
// TCK/TMS/TDI sequences for a target TAP and returns captured TDO bits.
module jtag_scan_master #(
    parameter int CLK_DIV = 2,
    parameter int MAX_LEN = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [$clog2(MAX_LEN+1)-1:0] cmd_len,
    input  logic [MAX_LEN-1:0]           cmd_data,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [MAX_LEN-1:0]           rsp_data,
    output logic                         tck,
    output logic                         tms,
    output logic                         tdi,
    input  logic                         tdo
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);
    localparam logic [LW-1:0] IDX_ONE   = LW'(1);
    localparam logic [LW-1:0] IDX_TWO   = LW'(2);
    localparam logic [LW-1:0] IDX_THREE = LW'(3);
    localparam logic [LW-1:0] IDX_FOUR  = LW'(4);
    localparam logic [LW-1:0] IDX_FIVE  = LW'(5);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RESET = 3'd1;
    localparam logic [2:0] S_PRE   = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_POST  = 3'd4;
    localparam logic [2:0] S_RSP   = 3'd5;

    localparam logic [1:0] OP_RST  = 2'b00;
    localparam logic [1:0] OP_IR   = 2'b01;
    localparam logic [1:0] OP_DR   = 2'b10;
    localparam logic [1:0] OP_IDLE = 2'b11;

    logic [2:0]         r_state;
    logic [LW-1:0]      r_idx;
    logic [1:0]         r_op;
    logic [LW-1:0]      r_len;
    logic               r_tapSynced;
    logic [DW-1:0]      r_div;
    logic               r_tck;
    logic               r_tms;
    logic               r_tdi;
    logic [MAX_LEN-1:0] r_data;
    logic [MAX_LEN-1:0] r_mask;
    logic [MAX_LEN-1:0] r_rsp;

    logic          w_accept;
    logic [LW-1:0] w_lenClamp;
    logic          w_running;
    logic          w_halfDone;
    logic          w_rise;
    logic          w_tickDone;
    logic          w_shiftData;
    logic [1:0]    w_opSel;
    logic [LW-1:0] w_lenSel;
    logic [2:0]    w_bodyState;
    logic [LW-1:0] w_lastPre;
    logic [2:0]    w_nxState;
    logic [LW-1:0] w_nxIdx;
    logic          w_nxTms;

    assign w_accept    = cmd_valid && (r_state == S_IDLE);
    assign w_lenClamp  = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
    assign w_running   = (r_state == S_RESET) || (r_state == S_PRE) ||
                         (r_state == S_SHIFT) || (r_state == S_POST);
    assign w_halfDone  = (r_div == DIV_LAST);
    assign w_rise      = w_running && w_halfDone && !r_tck;
    assign w_tickDone  = w_running && w_halfDone && r_tck;
    assign w_shiftData = (r_state == S_SHIFT) && (r_op != OP_IDLE);
    assign w_opSel     = w_accept ? cmd_op : r_op;
    assign w_lenSel    = w_accept ? w_lenClamp : r_len;
    assign w_bodyState = (w_opSel == OP_IDLE) ? S_SHIFT : S_PRE;
    assign w_lastPre   = (r_op == OP_IR) ? IDX_FOUR : IDX_THREE;

    assign cmd_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RSP);
    assign rsp_data  = r_rsp;
    assign tck       = r_tck;
    assign tms       = r_tms;
    assign tdi       = r_tdi;

    // Pick the next sequence position, either on command accept or when a tick ends.
    always_comb begin
        w_nxState = r_state;
        w_nxIdx   = r_idx;
        if (w_accept) begin
            w_nxIdx = '0;
            case (cmd_op)
                OP_RST:       w_nxState = S_RESET;
                OP_IR, OP_DR: w_nxState = (w_lenClamp == '0) ? S_RSP :
                                          (!r_tapSynced ? S_RESET : S_PRE);
                default:      w_nxState = (w_lenClamp == '0) ? S_IDLE :
                                          (!r_tapSynced ? S_RESET : S_SHIFT);
            endcase
        end else if (w_tickDone) begin
            case (r_state)
                S_RESET: begin
                    if (r_idx != IDX_FIVE) begin
                        w_nxIdx = r_idx + IDX_ONE;
                    end else begin
                        w_nxIdx   = '0;
                        w_nxState = (r_op == OP_RST) ? S_IDLE : w_bodyState;
                    end
                end
                S_PRE: begin
                    if (r_idx != w_lastPre) begin
                        w_nxIdx = r_idx + IDX_ONE;
                    end else begin
                        w_nxIdx   = '0;
                        w_nxState = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_idx != (r_len - IDX_ONE)) begin
                        w_nxIdx = r_idx + IDX_ONE;
                    end else begin
                        w_nxIdx   = '0;
                        w_nxState = (r_op == OP_IDLE) ? S_IDLE : S_POST;
                    end
                end
                S_POST: begin
                    if (r_idx == '0) begin
                        w_nxIdx = IDX_ONE;
                    end else begin
                        w_nxIdx   = '0;
                        w_nxState = S_RSP;
                    end
                end
                default: w_nxState = r_state;
            endcase
        end
    end

    // TMS value for the tick that starts at the next sequence position.
    always_comb begin
        w_nxTms = r_tms;
        case (w_nxState)
            S_RESET: w_nxTms = (w_nxIdx != IDX_FIVE);
            S_PRE:   w_nxTms = (w_nxIdx == IDX_ONE) ||
                               ((w_opSel == OP_IR) && (w_nxIdx == IDX_TWO));
            S_SHIFT: w_nxTms = (w_opSel != OP_IDLE) && (w_nxIdx == (w_lenSel - IDX_ONE));
            S_POST:  w_nxTms = (w_nxIdx == '0);
            default: w_nxTms = r_tms;
        endcase
    end

    // TCK generator: low then high half-periods while a sequence runs, parked low otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_tck <= 1'b0;
        end else if (!w_running) begin
            r_div <= '0;
            r_tck <= 1'b0;
        end else if (w_halfDone) begin
            r_div <= '0;
            r_tck <= ~r_tck;
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    // Sequencer state, TMS and the sticky TAP-synchronised flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_op        <= OP_RST;
            r_len       <= '0;
            r_tms       <= 1'b1;
            r_tapSynced <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= cmd_op;
                r_len <= w_lenClamp;
            end
            if (w_accept || w_tickDone) begin
                r_state <= w_nxState;
                r_idx   <= w_nxIdx;
                r_tms   <= w_nxTms;
            end else if ((r_state == S_RSP) && rsp_ready) begin
                r_state <= S_IDLE;
            end
            if (w_tickDone && (r_state == S_RESET) && (r_idx == IDX_FIVE)) begin
                r_tapSynced <= 1'b1;
            end
        end
    end

    // Shift data out on TDI LSB first and collect TDO into the bit selected by the one-hot mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_mask <= '0;
            r_rsp  <= '0;
            r_tdi  <= 1'b0;
        end else if (w_accept) begin
            r_data <= cmd_data;
            r_mask <= {{(MAX_LEN-1){1'b0}}, 1'b1};
            r_rsp  <= '0;
            r_tdi  <= 1'b0;
        end else begin
            if (w_rise && w_shiftData && tdo) begin
                r_rsp <= r_rsp | r_mask;
            end
            if (w_tickDone) begin
                if (w_shiftData) begin
                    r_mask <= r_mask << 1;
                    r_data <= r_data >> 1;
                end
                if ((w_nxState == S_SHIFT) && (r_op != OP_IDLE)) begin
                    r_tdi <= (r_state == S_SHIFT) ? r_data[1] : r_data[0];
                end else begin
                    r_tdi <= 1'b0;
                end
            end
        end
    end

endmodule
